// File: rtl/rst_seq_mgr_pkg.sv
// Shared types and constants for the reset sequence manager.
// Holds the sequencer state encoding, the reset-cause codes and a small width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR  = 2'd0;
    localparam cause_t CAUSE_SW   = 2'd1;
    localparam cause_t CAUSE_WDOG = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_mgr_if.sv
// Control/status bundle between firmware-facing logic and the reset sequence manager.
// The master side issues requests; the slave side (the manager) reports domain resets and cause.
interface rst_seq_mgr_if #(
    parameter int N_OUT = 4
);
    import rst_seq_pkg::*;

    logic             sw_rst_req;
    logic             wdog_en;
    logic             wdog_kick;
    logic [N_OUT-1:0] rst_out;
    logic             busy;
    cause_t           cause;

    modport master (
        output sw_rst_req, wdog_en, wdog_kick,
        input  rst_out, busy, cause
    );

    modport slave (
        input  sw_rst_req, wdog_en, wdog_kick,
        output rst_out, busy, cause
    );

endinterface

// File: rtl/rst_seq_mgr_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES rising edges.
// Kept generic so other clock domains can reuse it.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_reset
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_mgr.sv
// Reset sequence manager: stretched, staggered release of N_OUT reset domains with
// software reset, a RUN-state watchdog and a reset-cause register.
module rst_seq_mgr
    import rst_seq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int STRETCH     = 65535,
    parameter int STEP        = 256,
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_CYC    = 2**24
) (
    input  logic              clk,
    input  logic              reset,
    rst_seq_mgr_if.slave      bus
);

    localparam int CNT_W = max_int($clog2(STRETCH + 1), $clog2(STEP));
    localparam int IDX_W = $clog2(N_OUT + 1);
    localparam int WD_W  = $clog2(WDOG_CYC);

    localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUT - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WDOG_CYC - 1);

    logic             sync_reset;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
    logic [N_OUT-1:0] rst_q, rst_n;
    cause_t           cause_q, cause_n;
    logic             timeout;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (sync_reset)
    );

    // The synchronised reset asserts asynchronously with the button, so rst_out rises without a clock.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state   <= HOLD;
            cnt     <= STRETCH_C;
            idx     <= '0;
            wd_cnt  <= '0;
            rst_q   <= '1;
            cause_q <= CAUSE_POR;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            wd_cnt  <= wd_cnt_n;
            rst_q   <= rst_n;
            cause_q <= cause_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        wd_cnt_n = wd_cnt;
        rst_n    = rst_q;
        cause_n  = cause_q;
        timeout  = 1'b0;

        case (state)
            HOLD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    rst_n[0] = 1'b0;
                    cnt_n    = STEP_C;
                    idx_n    = IDX_W'(1);
                    state_n  = (N_OUT == 1) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (idx == IDX_W'(i)) rst_n[i] = 1'b0;
                    end
                    cnt_n = STEP_C;
                    idx_n = idx + 1'b1;
                    if (idx == LAST_IDX) state_n = RUN;
                end
            end
            RUN: begin
                rst_n = '0;
                if (!bus.wdog_en || bus.wdog_kick) begin
                    wd_cnt_n = '0;
                end else if (wd_cnt == WD_LAST) begin
                    timeout = 1'b1;
                end else begin
                    wd_cnt_n = wd_cnt + 1'b1;
                end
            end
            default: state_n = HOLD;
        endcase

        // Software request outranks a watchdog expiry landing on the same edge.
        if (bus.sw_rst_req || timeout) begin
            rst_n    = '1;
            state_n  = HOLD;
            cnt_n    = STRETCH_C;
            idx_n    = '0;
            wd_cnt_n = '0;
            cause_n  = bus.sw_rst_req ? CAUSE_SW : CAUSE_WDOG;
        end
    end

    assign bus.rst_out = rst_q;
    assign bus.busy    = |rst_q;
    assign bus.cause   = cause_q;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Self-checking bench for rst_seq_mgr: directed scenarios plus random traffic,
// compared every cycle against a timeline-based reference model.
module tb_rst_seq_mgr;
    import rst_seq_pkg::*;

    localparam int N_OUT       = 3;
    localparam int STRETCH     = 8;
    localparam int STEP        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int WDOG_CYC    = 16;

    logic clk;
    logic reset;

    int total;
    int bad;

    // Reference model: edges elapsed since the sequence origin, watchdog run length, cause.
    int     m_t;
    int     m_wd;
    int     m_sync;
    cause_t m_cause;
    logic   en_r;

    rst_seq_mgr_if #(.N_OUT(N_OUT)) bus ();

    rst_seq_mgr #(
        .N_OUT       (N_OUT),
        .STRETCH     (STRETCH),
        .STEP        (STEP),
        .SYNC_STAGES (SYNC_STAGES),
        .WDOG_CYC    (WDOG_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] exp_rst();
        logic [N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) begin
            r[k] = !(m_sync == 0 && m_t > STRETCH + k * STEP);
        end
        return r;
    endfunction

    function automatic logic model_run();
        return (m_sync == 0) && (m_t > STRETCH + (N_OUT - 1) * STEP);
    endfunction

    task automatic model_async();
        m_t     = 0;
        m_wd    = 0;
        m_cause = CAUSE_POR;
        m_sync  = SYNC_STAGES;
    endtask

    task automatic model_edge(input logic sw, input logic en, input logic kick);
        logic was_run;
        if (reset) begin
            model_async();
        end else if (m_sync > 0) begin
            m_sync--;
        end else begin
            was_run = model_run();
            if (sw) begin
                m_t = 0; m_wd = 0; m_cause = CAUSE_SW;
            end else if (was_run && en && !kick && m_wd == WDOG_CYC - 1) begin
                m_t = 0; m_wd = 0; m_cause = CAUSE_WDOG;
            end else begin
                if (was_run) m_wd = (en && !kick) ? m_wd + 1 : 0;
                if (m_t < 1000) m_t++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic en, input logic kick);
        bus.sw_rst_req = sw;
        bus.wdog_en    = en;
        bus.wdog_kick  = kick;
        @(posedge clk);
        model_edge(sw, en, kick);
        @(negedge clk);
        checkOutput("rst_out", 32'(bus.rst_out), 32'(exp_rst()));
        checkOutput("busy", 32'(bus.busy), 32'(exp_rst() != '0));
        checkOutput("cause", 32'(bus.cause), 32'(m_cause));
    endtask

    // Raise the button between edges and confirm the immediate, clockless response.
    task automatic doAsyncReset(input int hold);
        #1 reset = 1'b1;
        model_async();
        #1;
        checkOutput("async_rst_out", 32'(bus.rst_out), 32'(3'b111));
        checkOutput("async_busy", 32'(bus.busy), 32'd1);
        checkOutput("async_cause", 32'(bus.cause), 32'(CAUSE_POR));
        repeat (hold) applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic waitRun(input logic en);
        int n = 0;
        while (!model_run() && n < 200) begin
            applyStimulus(1'b0, en, 1'b0);
            n++;
        end
        checkOutput("run_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.wdog_en    = 1'b0;
        bus.wdog_kick  = 1'b0;
        model_async();
        #1 reset = 1'b1;
        @(negedge clk);

        $display("[TB] power-on reset");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (22) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] software reset in RUN");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sw_cause", 32'(bus.cause), 32'(CAUSE_SW));
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] watchdog expiry and kicked run");
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b0);
        waitRun(1'b1);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, (i % 10) == 0);
        checkOutput("kicked_no_reset", 32'(bus.rst_out), 32'd0);

        $display("[TB] async reset mid-release");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pre_async", 32'(bus.rst_out), 32'(3'b110));
        doAsyncReset(2);
        repeat (22) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] software reset during HOLD");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("hold_restart_held", 32'(bus.rst_out), 32'(3'b111));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("hold_restart_rel0", 32'(bus.rst_out), 32'(3'b110));

        $display("[TB] same-cycle events");
        waitRun(1'b0);
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sw_beats_wdog", 32'(bus.cause), 32'(CAUSE_SW));
        waitRun(1'b1);
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("kick_beats_timeout", 32'(bus.rst_out), 32'd0);
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wd_restarted", 32'(bus.rst_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("late_timeout_rst", 32'(bus.rst_out), 32'(3'b111));
        checkOutput("late_timeout_cause", 32'(bus.cause), 32'(CAUSE_WDOG));

        $display("[TB] random traffic");
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                doAsyncReset(1 + int'($urandom_range(0, 2)));
            end else begin
                if ($urandom_range(0, 99) == 0) en_r = ~en_r;
                applyStimulus($urandom_range(0, 63) == 0, en_r, $urandom_range(0, 19) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
